// File: rtl/regfile_2w4r_pkg.sv
// regfile_2w4r shared types: write-back bus layout and storage view.
// Optional feature macro RF_WRITE_THROUGH_EN is used by rf_read_port.
package regfile_2w4r_pkg;

    localparam int DATA_WD = 32;
    localparam int ADDR_WD = 5;
    localparam int NREG    = 1 << ADDR_WD;

    // One write port: enable, address, data.
    localparam int WR_PORT_WD = 1 + ADDR_WD + DATA_WD;

    // Matches `WS_TO_RF_BUS_WD in mycpu.h (76 bits).
    localparam int WS_TO_RF_BUS_WD = 2 * WR_PORT_WD;

    typedef struct packed {
        logic               we;
        logic [ADDR_WD-1:0] addr;
        logic [DATA_WD-1:0] data;
    } rf_wr_t;

    // Slot 2 occupies the upper half of the bus.
    typedef struct packed {
        rf_wr_t p2;
        rf_wr_t p1;
    } ws_to_rf_t;

    typedef logic [NREG-1:0][DATA_WD-1:0] rf_array_t;

    // A write port hits an address when enabled and not targeting r0.
    function automatic logic wr_hits(
        input rf_wr_t             w,
        input logic [ADDR_WD-1:0] a
    );
        return w.we && (w.addr == a) && (a != '0);
    endfunction

endpackage

// File: rtl/regfile_2w4r_read_port.sv
// rf_read_port: one combinational read port with r0 forcing.
// RF_WRITE_THROUGH_EN adds same-cycle bypass of write data.
module rf_read_port
    import regfile_2w4r_pkg::*;
(
    input  logic               reset,
    input  logic [ADDR_WD-1:0] raddr,
    input  rf_array_t          regs,
    input  rf_wr_t             wr1,
    input  rf_wr_t             wr2,
    output logic [DATA_WD-1:0] rdata
);

`ifdef RF_WRITE_THROUGH_EN
    // Slot 2 bypass first so the younger write wins, then slot 1.
    always_comb begin
        rdata = '0;
        if (raddr != '0) begin
            if (!reset && wr_hits(wr2, raddr)) begin
                rdata = wr2.data;
            end else if (!reset && wr_hits(wr1, raddr)) begin
                rdata = wr1.data;
            end else begin
                rdata = regs[raddr];
            end
        end
    end
`else
    // Stored contents only; r0 always reads zero.
    always_comb begin
        rdata = '0;
        if (raddr != '0) begin
            rdata = regs[raddr];
        end
    end

    // Write-port fields only matter for the bypass build.
    logic unused_wr;
    assign unused_wr = ^{reset, wr1, wr2};
`endif

endmodule

// File: rtl/regfile_2w4r.sv
// regfile_2w4r: 32x32 register file, two write ports, four reads.
// Define RF_WRITE_THROUGH_EN for same-cycle write-to-read bypass.
module regfile_2w4r
    import regfile_2w4r_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus,
    input  logic [ADDR_WD-1:0]         raddr1,
    input  logic [ADDR_WD-1:0]         raddr2,
    input  logic [ADDR_WD-1:0]         raddr3,
    input  logic [ADDR_WD-1:0]         raddr4,
    output logic [DATA_WD-1:0]         rdata1,
    output logic [DATA_WD-1:0]         rdata2,
    output logic [DATA_WD-1:0]         rdata3,
    output logic [DATA_WD-1:0]         rdata4
);

    ws_to_rf_t bus;
    rf_array_t regs;

    assign bus = ws_to_rf_t'(ws_to_rf_bus);

    // Storage update: reset clears, slot 2 beats slot 1, r0 stays 0.
    always_ff @(posedge clk) begin
        regs[0] <= '0;
        for (int i = 1; i < NREG; i++) begin
            if (reset) begin
                regs[i] <= '0;
            end else if (wr_hits(bus.p2, ADDR_WD'(i))) begin
                regs[i] <= bus.p2.data;
            end else if (wr_hits(bus.p1, ADDR_WD'(i))) begin
                regs[i] <= bus.p1.data;
            end
        end
    end

    rf_read_port u_rp1 (
        .reset (reset),
        .raddr (raddr1),
        .regs  (regs),
        .wr1   (bus.p1),
        .wr2   (bus.p2),
        .rdata (rdata1)
    );

    rf_read_port u_rp2 (
        .reset (reset),
        .raddr (raddr2),
        .regs  (regs),
        .wr1   (bus.p1),
        .wr2   (bus.p2),
        .rdata (rdata2)
    );

    rf_read_port u_rp3 (
        .reset (reset),
        .raddr (raddr3),
        .regs  (regs),
        .wr1   (bus.p1),
        .wr2   (bus.p2),
        .rdata (rdata3)
    );

    rf_read_port u_rp4 (
        .reset (reset),
        .raddr (raddr4),
        .regs  (regs),
        .wr1   (bus.p1),
        .wr2   (bus.p2),
        .rdata (rdata4)
    );

endmodule
